// File: rtl/idst7_pkg.sv
// rtl/idst7_pkg.sv - shared constants and width helpers for the idst7 multiply/round pipe
package idst7_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 6;
    localparam int SHIFT_MIN     = 0;
    localparam int SHIFT_MAX     = 31;
    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 63;

    // Rounding and clipping run at this width; it holds the widest legal product plus carry.
    localparam int EXT_WIDTH = 128;

    function automatic int prod_width(input int din0_width, input int din1_width,
                                      input int din0_signed);
        return din0_width + din1_width + ((din0_signed != 0) ? 0 : 1);
    endfunction

    function automatic logic signed [EXT_WIDTH-1:0] clip_max(input int dout_width);
        logic signed [EXT_WIDTH-1:0] r;
        r = '0;
        r[dout_width-1] = 1'b1;
        return r - 1;
    endfunction

    function automatic logic signed [EXT_WIDTH-1:0] clip_min(input int dout_width);
        logic signed [EXT_WIDTH-1:0] r;
        r = '0;
        r[dout_width-1] = 1'b1;
        return -r;
    endfunction

    function automatic logic signed [EXT_WIDTH-1:0] round_const(input int shift);
        logic signed [EXT_WIDTH-1:0] r;
        r = '0;
        if (shift > 0) begin
            r[shift-1] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/idst7_round_sat.sv
// rtl/idst7_round_sat.sv - combinational round-half-up, arithmetic shift and clip/truncate
module idst7_round_sat
    import idst7_pkg::*;
#(
    parameter int IN_WIDTH   = 40,
    parameter int DOUT_WIDTH = 32,
    parameter int SHIFT      = 0,
    parameter int SAT        = 0
) (
    input  logic signed [IN_WIDTH-1:0]   din,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         clip
);

    localparam logic signed [EXT_WIDTH-1:0] RND = round_const(SHIFT);
    localparam logic signed [EXT_WIDTH-1:0] HI  = clip_max(DOUT_WIDTH);
    localparam logic signed [EXT_WIDTH-1:0] LO  = clip_min(DOUT_WIDTH);

    logic signed [EXT_WIDTH-1:0] scaled;
    logic                        over_hi;
    logic                        over_lo;

    always_comb begin
        scaled  = (EXT_WIDTH'(din) + RND) >>> SHIFT;
        over_hi = scaled > HI;
        over_lo = scaled < LO;
        clip    = (SAT != 0) && (over_hi || over_lo);
        if ((SAT != 0) && over_hi) begin
            dout = HI[DOUT_WIDTH-1:0];
        end else if ((SAT != 0) && over_lo) begin
            dout = LO[DOUT_WIDTH-1:0];
        end else begin
            dout = scaled[DOUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/idst7_mul_rnd_pipe.sv
// rtl/idst7_mul_rnd_pipe.sv - pipelined coefficient multiply with rounding, shift and saturation
module idst7_mul_rnd_pipe
    import idst7_pkg::*;
#(
    parameter int DIN0_WIDTH  = 7,
    parameter int DIN1_WIDTH  = 32,
    parameter int DOUT_WIDTH  = 32,
    parameter int NUM_STAGE   = 2,
    parameter int DIN0_SIGNED = 0,
    parameter int SHIFT       = 0,
    parameter int SAT         = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic [DIN0_WIDTH-1:0]        din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         sat_flag,
    input  logic                         sat_clr
);

    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH, DIN0_SIGNED);
    localparam int AW = DIN0_WIDTH + ((DIN0_SIGNED != 0) ? 0 : 1);

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
        $error("idst7_mul_rnd_pipe: NUM_STAGE out of range");
    end
    if (SHIFT < SHIFT_MIN || SHIFT > SHIFT_MAX) begin : g_bad_shift
        $error("idst7_mul_rnd_pipe: SHIFT out of range");
    end
    if (DIN0_WIDTH < WIDTH_MIN || DIN0_WIDTH > WIDTH_MAX || DIN1_WIDTH < WIDTH_MIN
        || DIN1_WIDTH > WIDTH_MAX || DOUT_WIDTH < WIDTH_MIN || DOUT_WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("idst7_mul_rnd_pipe: operand or result width out of range");
    end

    logic                    adv;
    logic signed [AW-1:0]    coef;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    final_data;
    logic                    final_valid;
    logic signed [DOUT_WIDTH-1:0] rs_dout;
    logic                    rs_clip;

    // Whole pipe advances together: only when the output slot is free or being drained.
    assign adv      = ce & (~out_valid | out_ready);
    assign in_ready = adv;

    if (DIN0_SIGNED != 0) begin : g_coef_signed
        assign coef = din0;
    end else begin : g_coef_unsigned
        assign coef = {1'b0, din0};
    end

    assign prod = PW'(coef) * PW'(din1);

    if (NUM_STAGE == 1) begin : g_direct
        assign final_data  = prod;
        assign final_valid = in_valid;
    end else begin : g_delay
        logic signed [PW-1:0]  pipe_data [NUM_STAGE-1];
        logic [NUM_STAGE-2:0]  pipe_valid;

        always_ff @(posedge clk) begin
            if (reset) begin
                pipe_valid <= '0;
            end else if (adv) begin
                pipe_valid[0] <= in_valid;
                for (int i = 1; i < NUM_STAGE - 1; i++) begin
                    pipe_valid[i] <= pipe_valid[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                pipe_data[0] <= prod;
                for (int i = 1; i < NUM_STAGE - 1; i++) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end

        assign final_data  = pipe_data[NUM_STAGE-2];
        assign final_valid = pipe_valid[NUM_STAGE-2];
    end

    idst7_round_sat #(
        .IN_WIDTH   (PW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT),
        .SAT        (SAT)
    ) u_round_sat (
        .din  (final_data),
        .dout (rs_dout),
        .clip (rs_clip)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (adv) begin
                out_valid <= final_valid;
                if (final_valid) begin
                    dout <= rs_dout;
                end
            end
            // A clip entering the output wins over a same-cycle clear.
            if (adv && final_valid && rs_clip) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_idst7_mul_rnd_pipe.sv
// tb/tb_idst7_mul_rnd_pipe.sv - directed self-checking bench for idst7_mul_rnd_pipe
module tb_idst7_mul_rnd_pipe;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    always #5 clk = ~clk;

    logic              d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_sat_flag, d_sat_clr;
    logic [6:0]        d_din0;
    logic signed [31:0] d_din1;
    logic signed [31:0] d_dout;

    logic              s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_sat_flag, s_sat_clr;
    logic [6:0]        s_din0;
    logic signed [31:0] s_din1;
    logic signed [31:0] s_dout;

    logic              t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_sat_flag, t_sat_clr;
    logic [6:0]        t_din0;
    logic signed [31:0] t_din1;
    logic signed [15:0] t_dout;

    idst7_mul_rnd_pipe u_def (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(d_in_valid), .din0(d_din0), .din1(d_din1),
        .in_ready(d_in_ready), .out_valid(d_out_valid), .out_ready(d_out_ready), .dout(d_dout),
        .sat_flag(d_sat_flag), .sat_clr(d_sat_clr)
    );

    idst7_mul_rnd_pipe #(.NUM_STAGE(1), .SHIFT(6)) u_shf (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(s_in_valid), .din0(s_din0), .din1(s_din1),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(s_out_ready), .dout(s_dout),
        .sat_flag(s_sat_flag), .sat_clr(s_sat_clr)
    );

    idst7_mul_rnd_pipe #(.DOUT_WIDTH(16), .NUM_STAGE(3), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(t_in_valid), .din0(t_din0), .din1(t_din1),
        .in_ready(t_in_ready), .out_valid(t_out_valid), .out_ready(t_out_ready), .dout(t_dout),
        .sat_flag(t_sat_flag), .sat_clr(t_sat_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    int v0 [8] = '{1, 127, 0, 10, 100, 3, 127, 127};
    int v1 [8] = '{5, -1, 12345, -10, 100, -7, 32'h7fff_ffff, 32'h8000_0000};
    logic signed [63:0] exp_tab [8] = '{64'sd5, -64'sd127, 64'sd0, -64'sd100, 64'sd10000,
                                        -64'sd21, 64'sd2147483521, -64'sd2147483648};

    int acc [8];
    int k, got, c, adv_cnt;
    logic hold_pend, hv, seen;
    logic signed [31:0] hd;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; ce = 1'b1;
        d_in_valid = 0; d_din0 = 0; d_din1 = 0; d_out_ready = 1; d_sat_clr = 0;
        s_in_valid = 0; s_din0 = 0; s_din1 = 0; s_out_ready = 1; s_sat_clr = 0;
        t_in_valid = 0; t_din0 = 0; t_din1 = 0; t_out_ready = 1; t_sat_clr = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_def_valid", d_out_valid, 0);
        check_eq("rst_def_dout", d_dout, 0);
        check_eq("rst_def_sat", d_sat_flag, 0);
        check_eq("rst_shf_valid", s_out_valid, 0);
        check_eq("rst_shf_dout", s_dout, 0);
        check_eq("rst_sat_valid", t_out_valid, 0);
        check_eq("rst_sat_dout", t_dout, 0);
        check_eq("rst_sat_flag", t_sat_flag, 0);
        reset = 1'b0;

        // 64 * -3 with two-cycle latency
        d_in_valid = 1; d_din0 = 64; d_din1 = -3;
        @(negedge clk);
        check_eq("def_lat1_valid", d_out_valid, 0);
        d_in_valid = 0;
        @(negedge clk);
        check_eq("def_valid", d_out_valid, 1);
        check_eq("def_dout", d_dout, -192);

        // SHIFT=6, single stage
        s_in_valid = 1; s_din0 = 29; s_din1 = 100;
        @(negedge clk);
        check_eq("shf_pos_valid", s_out_valid, 1);
        check_eq("shf_pos", s_dout, 45);
        s_din1 = -100;
        @(negedge clk);
        check_eq("shf_neg_valid", s_out_valid, 1);
        check_eq("shf_neg", s_dout, -45);
        s_in_valid = 0;

        // saturation, clear, and set-beats-clear
        t_in_valid = 1; t_din0 = 127; t_din1 = 1000;
        @(negedge clk);
        t_in_valid = 0;
        for (int i = 0; i < 8 && !t_out_valid; i++) @(negedge clk);
        check_eq("sat_hi_valid", t_out_valid, 1);
        check_eq("sat_hi", t_dout, 32767);
        check_eq("sat_hi_flag", t_sat_flag, 1);
        t_sat_clr = 1;
        @(negedge clk);
        check_eq("sat_clr_flag", t_sat_flag, 0);
        t_in_valid = 1; t_din1 = -1000;
        @(negedge clk);
        t_in_valid = 0;
        for (int i = 0; i < 8 && !t_out_valid; i++) @(negedge clk);
        check_eq("sat_lo_valid", t_out_valid, 1);
        check_eq("sat_lo", t_dout, -32768);
        check_eq("sat_lo_flag_set_wins", t_sat_flag, 1);
        t_sat_clr = 0;

        // back-to-back stream with output stall and ce freeze
        k = 0; got = 0; c = 0; adv_cnt = 0; hold_pend = 0; hv = 0; hd = 0;
        while (got < 8 && c < 80) begin
            if (hold_pend) begin
                check_eq("hold_dout", d_dout, hd);
                check_eq("hold_valid", d_out_valid, hv);
                hold_pend = 0;
            end
            d_in_valid = (k < 8);
            if (k < 8) begin
                d_din0 = 7'(v0[k]);
                d_din1 = v1[k];
            end
            d_out_ready = !(c >= 4 && c <= 6);
            ce = !(c >= 10 && c <= 11);
            #1;
            if (!ce || (d_out_valid && !d_out_ready))
                check_eq("stall_in_ready", d_in_ready, 0);
            if (!d_in_ready) begin
                hold_pend = 1; hv = d_out_valid; hd = d_dout;
            end
            if (d_out_valid && d_in_ready) begin
                check_eq($sformatf("stream_res%0d", got), d_dout, exp_tab[got]);
                check_eq($sformatf("stream_lat%0d", got), adv_cnt - acc[got], 2);
                got++;
            end
            if (d_in_valid && d_in_ready) begin
                acc[k] = adv_cnt;
                k++;
            end
            if (d_in_ready) adv_cnt++;
            @(negedge clk);
            c++;
        end
        check_eq("stream_count", got, 8);
        ce = 1; d_out_ready = 1; d_in_valid = 0;
        check_eq("trunc_no_sat", d_sat_flag, 0);

        // reset with two operands in flight, ce low
        d_in_valid = 1; d_din0 = 2; d_din1 = 3;
        @(negedge clk);
        d_din0 = 4; d_din1 = 5;
        @(negedge clk);
        d_in_valid = 0; reset = 1; ce = 0;
        @(negedge clk);
        check_eq("flight_rst_valid", d_out_valid, 0);
        check_eq("flight_rst_dout", d_dout, 0);
        reset = 0; ce = 1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_out_valid) seen = 1;
        end
        check_eq("flight_no_stale", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
